// File: rtl/tag_rx_seq_ctrl.sv
// RX sequencing controller: preamble peak -> programmable +/-AMP location-sync burst -> tag_rx start,
// then sync_ready wait with optional timeout, holdoff and re-arm.
module tag_rx_seq_ctrl #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned TO_W        = 24,
   parameter int unsigned NREP        = 7,
   parameter int unsigned AMP         = 16384,
   parameter int unsigned HOLDOFF_CYC = 1024,
   parameter int unsigned GPIO_W      = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  peak_tvalid,
   input  logic                  peak_stb,
   input  logic                  sync_ready,
   input  logic [CNT_W-1:0]      seg_len_p,
   input  logic [CNT_W-1:0]      seg_len_n,
   input  logic [CNT_W-1:0]      trig_delay,
   input  logic [TO_W-1:0]       timeout,
   output logic                  rx_valid,
   output logic                  rx_trig,
   output logic                  sync_sel,
   output logic [DATA_WIDTH-1:0] sync_i,
   output logic [DATA_WIDTH-1:0] sync_q,
   output logic [2:0]            state,
   output logic [15:0]           frame_cnt,
   output logic                  timeout_err,
   output logic [GPIO_W-1:0]     gpio_out,
   output logic [GPIO_W-1:0]     gpio_ddr
);
   localparam int unsigned PER_W = CNT_W + 1;
   localparam int unsigned TOT_W = CNT_W + $clog2(NREP) + 1;
   localparam int unsigned HO_W  = $clog2(HOLDOFF_CYC + 1);
   localparam int unsigned CW    = (TOT_W > HO_W) ? TOT_W : HO_W;
   localparam logic [DATA_WIDTH-1:0] AMP_P = DATA_WIDTH'(AMP);
   localparam logic [DATA_WIDTH-1:0] AMP_N = DATA_WIDTH'(0) - AMP_P;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_SYNC    = 3'd2,
      S_RX      = 3'd3,
      S_HOLDOFF = 3'd4
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CW-1:0]      r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [PER_W-1:0]   r_ph, w_ph_nxt;
   logic [TO_W-1:0]    r_tocnt, w_tocnt_nxt;
   logic [CNT_W-1:0]   r_len_p, r_len_n, r_trig_delay;
   logic [CNT_W-1:0]   w_len_p_nxt, w_len_n_nxt, w_trig_delay_nxt;
   logic [TO_W-1:0]    r_timeout, w_timeout_nxt;
   logic               r_rx_valid, r_rx_trig, r_sync_sel, r_timeout_err;
   logic               w_rx_valid_nxt, w_rx_trig_nxt, w_sync_sel_nxt, w_err_nxt;
   logic [15:0]        r_frame_cnt, w_frame_nxt;
   logic [GPIO_W-1:0]  r_gpio_out, w_gpio_nxt;
   logic               w_latch;
   logic [PER_W-1:0]   w_period;
   logic [TOT_W-1:0]   w_tot, w_trig_end;
   logic               w_trig_en;

   // Burst geometry from the latched configuration
   assign w_period   = PER_W'(r_len_p) + PER_W'(r_len_n);
   assign w_tot      = TOT_W'(NREP) * TOT_W'(w_period);
   assign w_trig_en  = TOT_W'(r_trig_delay) < w_tot;
   assign w_trig_end = w_tot - TOT_W'(r_trig_delay);
   assign w_cnt_inc  = r_cnt + CW'(1);
   assign w_gpio_nxt = GPIO_W'({r_timeout_err, r_rx_trig, r_sync_sel});

   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_ph_nxt         = r_ph;
      w_tocnt_nxt      = r_tocnt;
      w_rx_valid_nxt   = r_rx_valid;
      w_rx_trig_nxt    = r_rx_trig;
      w_sync_sel_nxt   = r_sync_sel;
      w_frame_nxt      = r_frame_cnt;
      w_err_nxt        = r_timeout_err;
      w_len_p_nxt      = r_len_p;
      w_len_n_nxt      = r_len_n;
      w_trig_delay_nxt = r_trig_delay;
      w_timeout_nxt    = r_timeout;
      w_latch          = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_ARMED;
            w_latch     = 1'b1;
         end
         S_ARMED: begin
            if (peak_tvalid && peak_stb) begin
               w_state_nxt    = S_SYNC;
               w_cnt_nxt      = '0;
               w_ph_nxt       = '0;
               w_rx_valid_nxt = 1'b1;
               w_sync_sel_nxt = 1'b1;
               w_rx_trig_nxt  = w_trig_en;
            end
         end
         S_SYNC: begin
            if (r_cnt == CW'(w_tot) - CW'(1)) begin
               w_state_nxt    = S_RX;
               w_tocnt_nxt    = '0;
               w_rx_trig_nxt  = 1'b0;
               w_sync_sel_nxt = 1'b0;
            end else begin
               w_cnt_nxt     = w_cnt_inc;
               w_ph_nxt      = (r_ph == w_period - PER_W'(1)) ? '0 : r_ph + PER_W'(1);
               w_rx_trig_nxt = w_trig_en && (w_cnt_inc < CW'(w_trig_end));
            end
         end
         S_RX: begin
            // A success on the timeout cycle takes priority over the error
            w_tocnt_nxt = r_tocnt + TO_W'(1);
            if (sync_ready && peak_tvalid) begin
               w_state_nxt    = S_HOLDOFF;
               w_cnt_nxt      = '0;
               w_rx_valid_nxt = 1'b0;
               w_frame_nxt    = r_frame_cnt + 16'd1;
            end else if ((r_timeout != '0) && (r_tocnt == r_timeout - TO_W'(1))) begin
               w_state_nxt    = S_HOLDOFF;
               w_cnt_nxt      = '0;
               w_rx_valid_nxt = 1'b0;
               w_err_nxt      = 1'b1;
            end
         end
         S_HOLDOFF: begin
            if (r_cnt == CW'(HOLDOFF_CYC - 1)) begin
               w_state_nxt = S_ARMED;
               w_latch     = 1'b1;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         default: begin
            w_state_nxt    = S_IDLE;
            w_rx_valid_nxt = 1'b0;
            w_rx_trig_nxt  = 1'b0;
            w_sync_sel_nxt = 1'b0;
         end
      endcase
      if (w_latch) begin
         w_len_p_nxt      = (seg_len_p == '0) ? CNT_W'(1) : seg_len_p;
         w_len_n_nxt      = (seg_len_n == '0) ? CNT_W'(1) : seg_len_n;
         w_trig_delay_nxt = trig_delay;
         w_timeout_nxt    = timeout;
      end
   end

   // run low acts as a soft clear that preserves the frame count and error flag
   always_ff @(posedge clk) begin
      if (reset || !run) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_ph         <= '0;
         r_tocnt      <= '0;
         r_len_p      <= '0;
         r_len_n      <= '0;
         r_trig_delay <= '0;
         r_timeout    <= '0;
         r_rx_valid   <= 1'b0;
         r_rx_trig    <= 1'b0;
         r_sync_sel   <= 1'b0;
         r_gpio_out   <= '0;
         if (reset) begin
            r_frame_cnt   <= '0;
            r_timeout_err <= 1'b0;
         end
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_ph          <= w_ph_nxt;
         r_tocnt       <= w_tocnt_nxt;
         r_len_p       <= w_len_p_nxt;
         r_len_n       <= w_len_n_nxt;
         r_trig_delay  <= w_trig_delay_nxt;
         r_timeout     <= w_timeout_nxt;
         r_rx_valid    <= w_rx_valid_nxt;
         r_rx_trig     <= w_rx_trig_nxt;
         r_sync_sel    <= w_sync_sel_nxt;
         r_frame_cnt   <= w_frame_nxt;
         r_timeout_err <= w_err_nxt;
         r_gpio_out    <= w_gpio_nxt;
      end
   end

   assign sync_i      = r_sync_sel ? ((r_ph < PER_W'(r_len_p)) ? AMP_P : AMP_N) : '0;
   assign sync_q      = '0;
   assign rx_valid    = r_rx_valid;
   assign rx_trig     = r_rx_trig;
   assign sync_sel    = r_sync_sel;
   assign state       = r_state;
   assign frame_cnt   = r_frame_cnt;
   assign timeout_err = r_timeout_err;
   assign gpio_out    = r_gpio_out;
   assign gpio_ddr    = GPIO_W'(3'b111);
endmodule

// File: tb/tb_tag_rx_seq_ctrl.sv
// Bench for tag_rx_seq_ctrl: directed frames plus randomized configurations, each checked
// against per-frame expectations derived arithmetically from the burst rules.
module tb_tag_rx_seq_ctrl;
   localparam int unsigned DW   = 16;
   localparam int unsigned CNW  = 16;
   localparam int unsigned TW   = 24;
   localparam int unsigned NREP = 2;
   localparam int unsigned HOLD = 1024;
   localparam int unsigned GW   = 12;
   localparam int unsigned AMPV = 16384;

   logic           clk = 1'b0;
   logic           reset, run, peak_tvalid, peak_stb, sync_ready;
   logic [CNW-1:0] seg_len_p, seg_len_n, trig_delay;
   logic [TW-1:0]  timeout;
   logic           rx_valid, rx_trig, sync_sel, timeout_err;
   logic [DW-1:0]  sync_i, sync_q;
   logic [2:0]     state;
   logic [15:0]    frame_cnt;
   logic [GW-1:0]  gpio_out, gpio_ddr;

   int checks = 0, failures = 0;
   int cur_lp, cur_ln, cur_td, cur_to, nxt_lp, nxt_ln, nxt_td, nxt_to;
   int exp_frame = 0;
   int exp_err = 0;
   int prev_trig, prev_sel;
   logic [DW-1:0] amp_p, amp_n;

   tag_rx_seq_ctrl #(.DATA_WIDTH(DW), .CNT_W(CNW), .TO_W(TW), .NREP(NREP), .AMP(AMPV),
                     .HOLDOFF_CYC(HOLD), .GPIO_W(GW)) dut (
      .clk(clk), .reset(reset), .run(run), .peak_tvalid(peak_tvalid), .peak_stb(peak_stb),
      .sync_ready(sync_ready), .seg_len_p(seg_len_p), .seg_len_n(seg_len_n),
      .trig_delay(trig_delay), .timeout(timeout), .rx_valid(rx_valid), .rx_trig(rx_trig),
      .sync_sel(sync_sel), .sync_i(sync_i), .sync_q(sync_q), .state(state),
      .frame_cnt(frame_cnt), .timeout_err(timeout_err), .gpio_out(gpio_out), .gpio_ddr(gpio_ddr));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] gpio_exp(input int err, input int trig, input int sel);
      return 32'((err << 2) | (trig << 1) | sel);
   endfunction

   task automatic set_cfg(input int lp, input int ln, input int td, input int to);
      seg_len_p  = CNW'(lp);
      seg_len_n  = CNW'(ln);
      trig_delay = CNW'(td);
      timeout    = TW'(to);
      nxt_lp = (lp == 0) ? 1 : lp;
      nxt_ln = (ln == 0) ? 1 : ln;
      nxt_td = td;
      nxt_to = to;
   endtask

   task automatic take_cfg();
      cur_lp = nxt_lp; cur_ln = nxt_ln; cur_td = nxt_td; cur_to = nxt_to;
   endtask

   // One frame from ARMED: burst, then RX ending in success at rdy_at or timeout (rdy_at < 0)
   task automatic do_frame(input int rdy_at);
      int p, tot, et, ei;
      p   = cur_lp + cur_ln;
      tot = int'(NREP) * p;
      chk("armed_state", 32'(state), 32'd1);
      peak_tvalid = 1'b0; peak_stb = 1'b1;
      step();
      chk("stb_no_valid", 32'(state), 32'd1);
      peak_tvalid = 1'b1; peak_stb = 1'b1;
      step();
      peak_tvalid = 1'b0; peak_stb = 1'b0;
      prev_trig = 0; prev_sel = 0;
      for (int k = 0; k < tot; k++) begin
         et = ((cur_td < tot) && (k < tot - cur_td)) ? 1 : 0;
         ei = ((k % p) < cur_lp) ? 1 : 0;
         chk("sync_state", 32'(state), 32'd2);
         chk("sync_sel", 32'(sync_sel), 32'd1);
         chk("sync_valid", 32'(rx_valid), 32'd1);
         chk("sync_trig", 32'(rx_trig), 32'(et));
         chk("sync_i", 32'(sync_i), (ei != 0) ? 32'(amp_p) : 32'(amp_n));
         chk("sync_q", 32'(sync_q), 32'd0);
         chk("sync_gpio", 32'(gpio_out), gpio_exp(exp_err, prev_trig, prev_sel));
         prev_trig = et; prev_sel = 1;
         seg_len_p = CNW'($urandom); seg_len_n = CNW'($urandom);
         trig_delay = CNW'($urandom); timeout = TW'($urandom_range(1, 5));
         step();
      end
      for (int j = 0; ; j++) begin
         chk("rx_state", 32'(state), 32'd3);
         chk("rx_trig", 32'(rx_trig), 32'd0);
         chk("rx_sel", 32'(sync_sel), 32'd0);
         chk("rx_valid", 32'(rx_valid), 32'd1);
         chk("rx_gpio", 32'(gpio_out), gpio_exp(exp_err, prev_trig, prev_sel));
         prev_trig = 0; prev_sel = 0;
         if (j == rdy_at) begin
            sync_ready = 1'b1; peak_tvalid = 1'b1;
         end else begin
            sync_ready = 1'($urandom); peak_tvalid = 1'b0;
         end
         step();
         sync_ready = 1'b0; peak_tvalid = 1'b0;
         if (j == rdy_at) begin
            exp_frame = (exp_frame + 1) % 65536;
            break;
         end
         if (cur_to != 0 && j == cur_to - 1) begin
            exp_err = 1;
            break;
         end
         if (j > 4000) begin
            chk("rx_bound", 32'(j), 32'(cur_to));
            break;
         end
      end
      chk("ho_state", 32'(state), 32'd4);
      chk("ho_valid", 32'(rx_valid), 32'd0);
      chk("frame_cnt", 32'(frame_cnt), 32'(exp_frame));
      chk("timeout_err", 32'(timeout_err), 32'(exp_err));
   endtask

   // Holdoff with peak strobes present; next configuration is presented for the re-arm latch
   task automatic holdoff(input int lp, input int ln, input int td, input int to);
      set_cfg(lp, ln, td, to);
      for (int h = 0; h < int'(HOLD); h++) begin
         if (state != 3'd4) begin
            chk("ho_len", 32'(h), 32'(HOLD));
            break;
         end
         if (h > 0) chk("ho_gpio", 32'(gpio_out), gpio_exp(exp_err, 0, 0));
         peak_tvalid = 1'b1; peak_stb = 1'($urandom);
         step();
      end
      peak_tvalid = 1'b0; peak_stb = 1'b0;
      take_cfg();
      chk("rearm_state", 32'(state), 32'd1);
      chk("rearm_gpio", 32'(gpio_out), gpio_exp(exp_err, 0, 0));
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_valid"}, 32'(rx_valid), 32'd0);
      chk({tag, "_trig"}, 32'(rx_trig), 32'd0);
      chk({tag, "_sel"}, 32'(sync_sel), 32'd0);
      chk({tag, "_i"}, 32'(sync_i), 32'd0);
      chk({tag, "_gpio"}, 32'(gpio_out), 32'd0);
      chk({tag, "_frame"}, 32'(frame_cnt), 32'(exp_frame));
      chk({tag, "_err"}, 32'(timeout_err), 32'(exp_err));
      chk({tag, "_ddr"}, 32'(gpio_ddr), 32'h007);
   endtask

   initial begin
      int lp, ln, td, to, rdy, tot;
      amp_p = DW'(AMPV);
      amp_n = DW'(0) - amp_p;
      reset = 1'b1; run = 1'b0; peak_tvalid = 1'b0; peak_stb = 1'b0; sync_ready = 1'b0;
      set_cfg(4, 4, 3, 0);
      repeat (3) step();
      check_cleared("rst");
      chk("rst_q", 32'(sync_q), 32'd0);

      reset = 1'b0; run = 1'b1;
      step();
      take_cfg();
      do_frame(5);
      holdoff(5, 3, 2, 30);
      do_frame(29);
      holdoff(4, 4, 3, 100);
      do_frame(-1);
      holdoff(0, 3, 16'hFFFF, 50);
      do_frame(10);

      for (int n = 0; n < 5; n++) begin
         lp = int'($urandom_range(0, 7));
         ln = int'($urandom_range(0, 7));
         td = int'($urandom_range(0, 20));
         to = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(10, 60));
         if (to == 0) rdy = int'($urandom_range(0, 40));
         else rdy = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, to - 1));
         holdoff(lp, ln, td, to);
         do_frame(rdy);
      end

      // Soft clear mid-burst
      holdoff(3, 2, 1, 40);
      peak_tvalid = 1'b1; peak_stb = 1'b1;
      step();
      peak_tvalid = 1'b0; peak_stb = 1'b0;
      repeat (3) begin
         chk("pre_drop_state", 32'(state), 32'd2);
         step();
      end
      run = 1'b0;
      step();
      check_cleared("drop");
      step();
      chk("drop_hold", 32'(state), 32'd0);

      // Reset mid-RX clears everything, including the frame count and error flag
      set_cfg(2, 2, 0, 0);
      run = 1'b1;
      step();
      take_cfg();
      chk("rerun_state", 32'(state), 32'd1);
      peak_tvalid = 1'b1; peak_stb = 1'b1;
      step();
      peak_tvalid = 1'b0; peak_stb = 1'b0;
      tot = int'(NREP) * (cur_lp + cur_ln);
      repeat (tot + 2) step();
      chk("pre_rst_state", 32'(state), 32'd3);
      reset = 1'b1;
      step();
      exp_frame = 0; exp_err = 0;
      check_cleared("rst_rx");
      reset = 1'b0;
      step();
      chk("post_rst_state", 32'(state), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
